// File: rtl/wb_pkg.sv
// Shared types and sizes for the register-file writeback port.
// Optional feature macro: WB_FWD_EN (forwarding query port).
package wb_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned NREG  = 1 << AW;

  // Request payload carried by either writeback source
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wd;
  } wb_req_t;

  // FIFO entry; valid drops on squash or pop
  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wd;
  } wb_ent_t;

endpackage

// File: rtl/wb_write_port_if.sv
// Bus bundle between the core writeback sources and wb_write_port.
// Optional feature macro: WB_FWD_EN adds the q_addr/q_hit/q_data query.
interface wb_write_port_if;
  import wb_pkg::*;

  logic            a_we;
  logic [AW-1:0]   a_rd;
  logic [XLEN-1:0] a_wd;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_rd;
  logic [XLEN-1:0] b_wd;
  logic [AW-1:0]   A3;
  logic            WE3;
  logic [XLEN-1:0] WD3;
  logic [NREG-1:0] pend_mask;
`ifdef WB_FWD_EN
  logic [AW-1:0]   q_addr;
  logic            q_hit;
  logic [XLEN-1:0] q_data;
`endif

  // Core side: issues writebacks, observes the file write and hazards
  modport master (
`ifdef WB_FWD_EN
    output q_addr,
    input  q_hit, q_data,
`endif
    output a_we, a_rd, a_wd, b_valid, b_rd, b_wd,
    input  b_ready, A3, WE3, WD3, pend_mask
  );

  // Write-port side
  modport slave (
`ifdef WB_FWD_EN
    input  q_addr,
    output q_hit, q_data,
`endif
    input  a_we, a_rd, a_wd, b_valid, b_rd, b_wd,
    output b_ready, A3, WE3, WD3, pend_mask
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer for long-latency writebacks with per-entry valid and
// squash-by-rd. Entries are exported oldest-first (index 0 is the head).
// Optional feature macro: WB_FWD_EN (no effect inside this module).
module wb_fifo
  import wb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_req_t       push_data,
  input  logic          pop,
  input  logic          squash_en,
  input  logic [AW-1:0] squash_rd,
  output wb_ent_t       head,
  output logic          full,
  output logic          empty,
  output wb_ent_t       ents [DEPTH]
);

  wb_ent_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  // Storage, pointers and occupancy; squash, pop and push share one edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_en && mem[i].valid && (mem[i].rd == squash_rd)) mem[i].valid <= 1'b0;
      end
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      if (push) begin
        mem[wr_ptr].valid <= 1'b1;
        mem[wr_ptr].rd    <= push_data.rd;
        mem[wr_ptr].wd    <= push_data.wd;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Age-ordered view of the storage
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ents[i] = mem[rd_ptr + PW'(i)];
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_write_port.sv
// Merges the ALU and long-latency writeback sources onto the register
// file's single write port, with squash of stale queued results, x0 drop
// and a pending-write mask for the hazard unit.
// Optional feature macro: WB_FWD_EN enables the forwarding query port.
module wb_write_port
  import wb_pkg::*;
(
  input logic            clk,
  input logic            rst,
  wb_write_port_if.slave bus
);

  logic            a_live;
  logic            b_xfer;
  logic            b_nz;
  logic            b_squash;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  wb_ent_t         head;
  wb_ent_t         ents [DEPTH];
  wb_req_t         push_data;

  logic            out_we;
  logic [AW-1:0]   out_rd;
  logic [XLEN-1:0] out_wd;
  logic            we3_q;
  logic [AW-1:0]   a3_q;
  logic [XLEN-1:0] wd3_q;
  logic [NREG-1:0] mask;

  assign a_live    = bus.a_we && (bus.a_rd != '0);
  assign b_xfer    = bus.b_valid && !full;
  assign b_nz      = (bus.b_rd != '0);
  assign b_squash  = a_live && (bus.b_rd == bus.a_rd);
  assign bypass    = !a_live && empty && b_xfer && b_nz;
  assign push      = b_xfer && b_nz && !b_squash && !bypass;
  assign push_data = '{rd: bus.b_rd, wd: bus.b_wd};

  wb_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .squash_en (a_live),
    .squash_rd (bus.a_rd),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .ents      (ents)
  );

  // Source select: ALU, then FIFO head (dead heads drain silently), then bypass
  always_comb begin
    out_we = 1'b0;
    out_rd = a3_q;
    out_wd = wd3_q;
    pop    = 1'b0;
    if (a_live) begin
      out_we = 1'b1;
      out_rd = bus.a_rd;
      out_wd = bus.a_wd;
    end else if (!empty) begin
      pop = 1'b1;
      if (head.valid) begin
        out_we = 1'b1;
        out_rd = head.rd;
        out_wd = head.wd;
      end
    end else if (bypass) begin
      out_we = 1'b1;
      out_rd = bus.b_rd;
      out_wd = bus.b_wd;
    end
  end

  // Write-port output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= out_we;
      a3_q  <= out_rd;
      wd3_q <= out_wd;
    end
  end

  // Pending-write mask over live queued entries; x0 is never pending
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ents[i].valid) mask[ents[i].rd] = 1'b1;
    end
    mask[0] = 1'b0;
  end

  assign bus.WE3       = we3_q;
  assign bus.A3        = a3_q;
  assign bus.WD3       = wd3_q;
  assign bus.b_ready   = !full;
  assign bus.pend_mask = mask;

`ifdef WB_FWD_EN
  logic            fifo_hit;
  logic [XLEN-1:0] fifo_data;

  // Youngest live FIFO match wins; scan runs oldest to youngest
  always_comb begin
    fifo_hit  = 1'b0;
    fifo_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ents[i].valid && (ents[i].rd == bus.q_addr)) begin
        fifo_hit  = 1'b1;
        fifo_data = ents[i].wd;
      end
    end
  end

  assign bus.q_hit  = (bus.q_addr != '0) && (fifo_hit || (we3_q && (a3_q == bus.q_addr)));
  assign bus.q_data = fifo_hit ? fifo_data : wd3_q;
`endif

endmodule
